// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage core.
// Arbitrates freeze, redirect, flush continuation and RAW stall by fixed
// priority. Also keeps saturating performance counters and a sticky
// stall-timeout watchdog.
module pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_STALL    = 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hazard_i,
    input  logic             redirect_i,
    input  logic             dmem_busy_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             stall_timeout_o
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL  = 2'b01,
        FLUSH  = 2'b10,
        FREEZE = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        R_FREEZE,
        R_REDIRECT,
        R_FLUSH,
        R_HAZARD,
        R_RUN
    } rule_t;

    localparam logic [1:0]       FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0]       STALL_MAX  = 8'(MAX_STALL);
    localparam logic [7:0]       STALL_LAST = 8'(MAX_STALL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state;
    rule_t            rule;
    logic [1:0]       flush_left;
    logic [7:0]       run_len;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_timeout;

    // Pick the single rule that applies this cycle, highest priority first.
    always_comb begin
        rule = R_RUN;
        if (dmem_busy_i)
            rule = R_FREEZE;
        else if (redirect_i)
            rule = R_REDIRECT;
        else if (flush_left != 2'd0)
            rule = R_FLUSH;
        else if (hazard_i)
            rule = R_HAZARD;
    end

    // Same-cycle stage-register controls; reset forces a NOP into IF/ID and ID/EX.
    always_comb begin
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        pipe_freeze_o  = 1'b0;
        if (rst_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
        end else begin
            case (rule)
                R_FREEZE: pipe_freeze_o = 1'b1;
                R_REDIRECT: begin
                    pc_write_o     = 1'b1;
                    if_id_write_o  = 1'b1;
                    if_id_flush_o  = 1'b1;
                    id_ex_bubble_o = 1'b1;
                end
                R_FLUSH: begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                    if_id_flush_o = 1'b1;
                end
                R_HAZARD: id_ex_bubble_o = 1'b1;
                default: begin
                    pc_write_o    = 1'b1;
                    if_id_write_o = 1'b1;
                end
            endcase
        end
    end

    // Sequencer state, flush countdown, stall run length, counters and watchdog.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= RUN;
            flush_left    <= 2'd0;
            run_len       <= 8'd0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else begin
            case (rule)
                R_FREEZE: state <= FREEZE;
                R_REDIRECT: begin
                    flush_left <= FLUSH_INIT;
                    state      <= (FLUSH_INIT != 2'd0) ? FLUSH : RUN;
                    run_len    <= 8'd0;
                    if (flush_cnt != '1)
                        flush_cnt <= flush_cnt + CNT_ONE;
                end
                R_FLUSH: begin
                    flush_left <= flush_left - 2'd1;
                    state      <= (flush_left > 2'd1) ? FLUSH : RUN;
                    run_len    <= 8'd0;
                end
                R_HAZARD: begin
                    state <= STALL;
                    if (stall_cnt != '1)
                        stall_cnt <= stall_cnt + CNT_ONE;
                    if (run_len < STALL_MAX)
                        run_len <= run_len + 8'd1;
                    // Fires on the cycle whose increment makes the run reach the limit.
                    if (run_len >= STALL_LAST)
                        stall_timeout <= 1'b1;
                end
                default: begin
                    state   <= RUN;
                    run_len <= 8'd0;
                end
            endcase
        end
    end

    assign state_o         = state;
    assign stall_cnt_o     = stall_cnt;
    assign flush_cnt_o     = flush_cnt;
    assign stall_timeout_o = stall_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl (FLUSH_CYCLES=2, MAX_STALL=8, CNT_W=4).
// The stimulus process pushes hand-computed expectations per cycle; the
// monitor pops and compares on the falling edge.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hazard = 1'b1;
    logic       redirect = 1'b1;
    logic       busy = 1'b1;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
    logic [1:0] state;
    logic [3:0] stall_cnt, flush_cnt;
    logic       stall_timeout;

    pipeline_ctrl #(.FLUSH_CYCLES(2), .MAX_STALL(8), .CNT_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .hazard_i       (hazard),
        .redirect_i     (redirect),
        .dmem_busy_i    (busy),
        .pc_write_o     (pc_write),
        .if_id_write_o  (if_id_write),
        .if_id_flush_o  (if_id_flush),
        .id_ex_bubble_o (id_ex_bubble),
        .pipe_freeze_o  (pipe_freeze),
        .state_o        (state),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
        .stall_timeout_o(stall_timeout)
    );

    always #5 clk = ~clk;

    // control vectors: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}
    localparam logic [4:0] C_RST = 5'b00110;
    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_STL = 5'b00010;
    localparam logic [4:0] C_RED = 5'b11110;
    localparam logic [4:0] C_FLC = 5'b11100;
    localparam logic [4:0] C_FRZ = 5'b00001;

    typedef struct packed {
        logic [4:0] ctrl;
        logic [1:0] st;
        logic [3:0] sc;
        logic [3:0] fc;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;
    logic done     = 1'b0;

    task automatic check(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    endtask

    // Drive one cycle of inputs and record what the DUT must show during it.
    task automatic step(input logic r, input logic h, input logic rd, input logic b,
                        input logic [4:0] c, input logic [1:0] s,
                        input int sc, input int fc, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; hazard = h; redirect = rd; busy = b;
        e.ctrl = c; e.st = s; e.sc = 4'(sc); e.fc = 4'(fc); e.to = to;
        q.push_back(e);
    endtask

    // Monitor: compare each recorded expectation against the DUT mid-cycle.
    initial begin
        exp_t e;
        int   id;
        id = 0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ctrl",          id, int'({pc_write, if_id_write, if_id_flush,
                                                 id_ex_bubble, pipe_freeze}), int'(e.ctrl));
                check("state",         id, int'(state),         int'(e.st));
                check("stall_cnt",     id, int'(stall_cnt),     int'(e.sc));
                check("flush_cnt",     id, int'(flush_cnt),     int'(e.fc));
                check("stall_timeout", id, int'(stall_timeout), int'(e.to));
                id++;
            end
        end
    end

    initial begin
        // reset with every input high
        step(1, 1, 1, 1, C_RST, 2'b00, 0, 0, 0);
        step(1, 1, 1, 1, C_RST, 2'b00, 0, 0, 0);
        step(0, 0, 0, 0, C_RUN, 2'b00, 0, 0, 0);

        // RAW stall, two cycles
        step(0, 1, 0, 0, C_STL, 2'b00, 0, 0, 0);
        step(0, 1, 0, 0, C_STL, 2'b01, 1, 0, 0);
        step(0, 0, 0, 0, C_RUN, 2'b01, 2, 0, 0);
        step(0, 0, 0, 0, C_RUN, 2'b00, 2, 0, 0);

        // redirect with hazard held high
        step(0, 1, 1, 0, C_RED, 2'b00, 2, 0, 0);
        step(0, 1, 0, 0, C_FLC, 2'b10, 2, 1, 0);
        step(0, 1, 0, 0, C_STL, 2'b00, 2, 1, 0);
        step(0, 0, 0, 0, C_RUN, 2'b01, 3, 1, 0);

        // busy for three cycles during the flush cycle
        step(0, 0, 1, 0, C_RED, 2'b00, 3, 1, 0);
        step(0, 0, 0, 1, C_FRZ, 2'b10, 3, 2, 0);
        step(0, 0, 0, 1, C_FRZ, 2'b11, 3, 2, 0);
        step(0, 0, 0, 1, C_FRZ, 2'b11, 3, 2, 0);
        step(0, 0, 0, 0, C_FLC, 2'b11, 3, 2, 0);
        step(0, 0, 0, 0, C_RUN, 2'b00, 3, 2, 0);

        // busy wins over simultaneous redirect and hazard; counters hold
        step(0, 1, 1, 1, C_FRZ, 2'b00, 3, 2, 0);
        step(0, 0, 0, 0, C_RUN, 2'b11, 3, 2, 0);

        // 7 stalls, gap, 7 stalls: no timeout; stall_cnt saturates at 15
        for (int k = 1; k <= 7; k++)
            step(0, 1, 0, 0, C_STL, (k == 1) ? 2'b00 : 2'b01, 3 + k - 1, 2, 0);
        step(0, 0, 0, 0, C_RUN, 2'b01, 10, 2, 0);
        for (int k = 1; k <= 7; k++)
            step(0, 1, 0, 0, C_STL, (k == 1) ? 2'b00 : 2'b01,
                 (10 + k - 1 > 15) ? 15 : 10 + k - 1, 2, 0);
        step(0, 0, 0, 0, C_RUN, 2'b01, 15, 2, 0);

        // reset in the middle of a stall
        step(0, 1, 0, 0, C_STL, 2'b00, 15, 2, 0);
        step(1, 1, 0, 0, C_RST, 2'b00, 0, 0, 0);
        step(0, 0, 0, 0, C_RUN, 2'b00, 0, 0, 0);

        // 8 consecutive stalls trip the watchdog, which stays set
        for (int k = 1; k <= 8; k++)
            step(0, 1, 0, 0, C_STL, (k == 1) ? 2'b00 : 2'b01, k - 1, 0, 0);
        step(0, 1, 0, 0, C_STL, 2'b01, 8, 0, 1);
        step(0, 0, 0, 0, C_RUN, 2'b01, 9, 0, 1);
        step(0, 0, 0, 0, C_RUN, 2'b00, 9, 0, 1);

        // 20 back-to-back redirects: each restarts the flush, flush_cnt saturates
        for (int k = 1; k <= 20; k++)
            step(0, 0, 1, 0, C_RED, (k == 1) ? 2'b00 : 2'b10,
                 9, (k - 1 > 15) ? 15 : k - 1, 1);
        step(0, 0, 0, 0, C_FLC, 2'b10, 9, 15, 1);
        step(0, 0, 0, 0, C_RUN, 2'b00, 9, 15, 1);

        // let the monitor drain, bounded
        for (int k = 0; k < 10 && q.size() > 0; k++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: simulation did not finish, expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
